// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache for the RV32IM MEM stage.
// Serves B/H/W loads and stores out of 16-byte lines and stalls the pipeline on
// a miss while it writes back a dirty victim and fetches the missing block.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   read, write         CPU load / store request (both high = no access)
//   funct3              access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address, writedata  CPU byte address and right-aligned store data
//   readdata            load result, sign/zero extended (0 when not a read hit)
//   busywait            CPU stall
//   mem_read/mem_write  block memory read / write request
//   mem_address         28-bit block address
//   mem_writedata       victim block (byte k at bits [8k+7:8k])
//   mem_readdata        fetched block, same byte order
//   mem_busywait        block memory busy
module dcache_direct_mapped #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [2:0]   funct3,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = 28 - INDEX_W;
  localparam int unsigned LINE_W  = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_e;

  state_e              state_q, state_d;
  logic                first_q;
  logic [LINE_W-1:0]   fill_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    addr_tag;
  logic                access;
  logic                hit;
  logic                store_hit;
  logic                fill_done;
  logic [LINE_W-1:0]   line;
  logic [LINE_W-1:0]   line_wr;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_word;

  // Address decode and lookup
  assign index     = address[4 +: INDEX_W];
  assign addr_tag  = address[31 -: TAG_W];
  assign access    = read ^ write;
  assign line      = data_q[index];
  assign hit       = valid_q[index] && (tag_q[index] == addr_tag);
  assign store_hit = write && !read && hit && (state_q == S_IDLE);

  // Stall whenever an access is outstanding and cannot complete this cycle
  assign busywait  = access && (!hit || (state_q != S_IDLE));

  // Next-state and memory-side handshake
  always_comb begin
    state_d       = state_q;
    fill_done     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (access && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[index], index};
        mem_writedata = line;
        // memory may not have raised busywait yet in the first cycle
        if (!first_q && !mem_busywait) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_read    = 1'b1;
        mem_address = address[31:4];
        if (!first_q && !mem_busywait) begin
          state_d   = S_UPDATE;
          fill_done = 1'b1;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, fill buffer and line status bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      fill_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      if (fill_done) begin
        fill_q <= mem_readdata;
      end
      if (state_q == S_UPDATE) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are not reset; valid bits guard them
  always_ff @(posedge clock) begin
    if (state_q == S_UPDATE) begin
      tag_q[index]  <= addr_tag;
      data_q[index] <= fill_q;
    end else if (store_hit) begin
      data_q[index] <= line_wr;
    end
  end

  // Store merge: only the addressed byte/half/word lanes change
  always_comb begin
    line_wr = line;
    case (funct3[1:0])
      2'b00:   line_wr[{address[3:0], 3'b000}   +: 8]  = writedata[7:0];
      2'b01:   line_wr[{address[3:1], 4'b0000}  +: 16] = writedata[15:0];
      default: line_wr[{address[3:2], 5'b00000} +: 32] = writedata;
    endcase
  end

  // Load extract and extension
  assign ld_byte = line[{address[3:0], 3'b000}   +: 8];
  assign ld_half = line[{address[3:1], 4'b0000}  +: 16];
  assign ld_word = line[{address[3:2], 5'b00000} +: 32];

  always_comb begin
    readdata = '0;
    if (read && hit && (state_q == S_IDLE)) begin
      case (funct3)
        3'b000:  readdata = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  readdata = {24'b0, ld_byte};
        3'b001:  readdata = {{16{ld_half[15]}}, ld_half};
        3'b101:  readdata = {16'b0, ld_half};
        default: readdata = ld_word;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped: directed vector table, hand-written
// miss/reset sequences, and random traffic checked against a flat byte-memory model
// plus a per-set residency model of the cache.
module tb_dcache_direct_mapped;

  logic         clock;
  logic         reset;
  logic         read;
  logic         write;
  logic [2:0]   funct3;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  dcache_direct_mapped dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .funct3       (funct3),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // Block memory behind the cache, and what it has seen
  logic [127:0] mem [logic [27:0]];
  int           mem_lat = 2;
  int           wb_cnt  = 0;
  int           rd_cnt  = 0;
  logic [27:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic [27:0]  rd_addr = '0;
  bit           overlap = 1'b0;

  // Flat CPU-visible memory (reference) and cache residency per set
  logic [7:0]   gmem [logic [31:0]];
  bit           r_valid [8];
  bit           r_dirty [8];
  logic [27:0]  r_blk   [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] init_block(input logic [27:0] ba);
    logic [127:0] b;
    if (ba == 28'h4)  return 128'h100F0E0D_0C0B0A09_08070605_04030201;
    if (ba == 28'h14) return 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    for (int w = 0; w < 4; w++) begin
      b[w*32 +: 32] = 32'(ba) * 32'h9E3779B1 + 32'(w) * 32'h01234567;
    end
    return b;
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] ba);
    if (mem.exists(ba)) return mem[ba];
    return init_block(ba);
  endfunction

  function automatic logic [7:0] gbyte(input logic [31:0] a);
    logic [127:0] b;
    if (gmem.exists(a)) return gmem[a];
    b = init_block(a[31:4]);
    return b[{a[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] golden_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) begin
      b[k*8 +: 8] = gbyte({ba, 4'(k)});
    end
    return b;
  endfunction

  function automatic logic [31:0] golden_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] a2;
    logic [31:0] a4;
    b  = gbyte(a);
    a2 = {a[31:1], 1'b0};
    a4 = {a[31:2], 2'b00};
    h  = {gbyte(a2 + 32'd1), gbyte(a2)};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return {gbyte(a4 + 32'd3), gbyte(a4 + 32'd2), gbyte(a4 + 32'd1), gbyte(a4)};
    endcase
  endfunction

  task automatic golden_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] a2;
    logic [31:0] a4;
    a2 = {a[31:1], 1'b0};
    a4 = {a[31:2], 2'b00};
    case (f3[1:0])
      2'b00: gmem[a] = wd[7:0];
      2'b01: begin
        gmem[a2]         = wd[7:0];
        gmem[a2 + 32'd1] = wd[15:8];
      end
      default: begin
        for (int k = 0; k < 4; k++) gmem[a4 + 32'(k)] = wd[k*8 +: 8];
      end
    endcase
  endtask

  // Block memory: busy for mem_lat cycles per request, then completes
  initial begin
    mem_busywait = 1'b0;
    mem_readdata = '0;
    forever begin
      @(posedge clock); #1;
      while (!reset && (mem_read || mem_write)) begin
        mem_busywait = 1'b1;
        repeat (mem_lat) @(posedge clock);
        #1;
        if (mem_write) begin
          wb_cnt++;
          wb_addr          = mem_address;
          wb_data          = mem_writedata;
          mem[mem_address] = mem_writedata;
        end else if (mem_read) begin
          rd_cnt++;
          rd_addr      = mem_address;
          mem_readdata = mem_get(mem_address);
        end
        mem_busywait = 1'b0;
        @(posedge clock); #1;
      end
    end
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap = 1'b1;
  end

  // One CPU access; starts and ends just after a rising edge
  task automatic cpu_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int stall);
    read = rd; write = wr; funct3 = f3; address = a; writedata = wd;
    stall = 0;
    @(negedge clock);
    while (busywait === 1'b1 && stall < 100) begin
      stall++;
      @(negedge clock);
    end
    if (stall >= 100) begin
      total++;
      bad++;
      $display("FAIL busywait_timeout: addr %0h still stalled after %0d cycles", a, stall);
    end
    rdata = readdata;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  // Access with full prediction from the reference models
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int stall);
    int           idx;
    logic [27:0]  blk;
    bit           hit;
    bit           ev;
    logic [27:0]  vblk;
    logic [127:0] vdata;
    int           wb0;
    int           rd0;
    int           exp_stall;
    idx       = int'(a[6:4]);
    blk       = a[31:4];
    hit       = r_valid[idx] && (r_blk[idx] == blk);
    ev        = !hit && r_valid[idx] && r_dirty[idx];
    vblk      = r_blk[idx];
    vdata     = golden_block(vblk);
    wb0       = wb_cnt;
    rd0       = rd_cnt;
    exp_stall = hit ? 0 : (3 + mem_lat + (ev ? mem_lat + 1 : 0));
    cpu_op(rd, wr, f3, a, wd, rdata, stall);
    chk("stall_cycles", 128'(stall), 128'(exp_stall));
    chk("writeback_count", 128'(wb_cnt - wb0), 128'(ev ? 1 : 0));
    if (ev) begin
      chk("writeback_addr", 128'(wb_addr), 128'(vblk));
      chk("writeback_data", wb_data, vdata);
    end
    if (!hit) begin
      chk("fetch_count", 128'(rd_cnt - rd0), 128'd1);
      chk("fetch_addr", 128'(rd_addr), 128'(blk));
    end
    if (rd) chk("load_data", 128'(rdata), 128'(golden_load(f3, a)));
    else    chk("store_readdata", 128'(rdata), 128'd0);
    if (!hit) begin
      r_valid[idx] = 1'b1;
      r_blk[idx]   = blk;
      r_dirty[idx] = 1'b0;
    end
    if (wr) begin
      r_dirty[idx] = 1'b1;
      golden_store(f3, a, wd);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_miss;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] rdata;
    int          stall;
    int          n;
    logic [24:0] tags [4];

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,         32'h04030201, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h43, 32'h00000084,  32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h43, 32'h0,         32'hFFFFFF84, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h43, 32'h0,         32'h00000084, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h42, 32'h0,         32'hFFFF8403, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h42, 32'h0,         32'h00008403, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,         32'h84030201, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h45, 32'hFFFFFFAA,  32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h44, 32'h0,         32'h0807AA05, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h4A, 32'h55551234,  32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h48, 32'h0,         32'h12340A09, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h4C, 32'hDEADBEEF,  32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h4C, 32'h0,         32'hDEADBEEF, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h4E, 32'h0,         32'hFFFFDEAD, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h4F, 32'h0,         32'hFFFFFFDE, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b100, 32'h41, 32'h0,         32'h00000002, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h4B, 32'h0,         32'h12340A09, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'b001, 32'h43, 32'h0,         32'hFFFF8403, 1'b0};

    for (int i = 0; i < 8; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
      r_blk[i]   = '0;
    end

    // Reset state
    reset = 1'b1; read = 1'b0; write = 1'b0; funct3 = 3'b000;
    address = '0; writedata = '0;
    #12;
    chk("reset_busywait",      128'(busywait),  128'd0);
    chk("reset_mem_read",      128'(mem_read),  128'd0);
    chk("reset_mem_write",     128'(mem_write), 128'd0);
    chk("reset_mem_address",   128'(mem_address), 128'd0);
    chk("reset_mem_writedata", mem_writedata,   128'd0);
    chk("reset_readdata",      128'(readdata),  128'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed vectors on block 0x4
    mem_lat = 2;
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, rdata, stall);
      chk($sformatf("vec%0d_readdata", i), 128'(rdata), 128'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_miss", i), 128'(stall != 0), 128'(vecs[i].exp_miss));
    end

    // Dirty conflict: same set, new tag
    run_op(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, rdata, stall);
    chk("conflict_readdata", 128'(rdata), 128'h13121110);
    chk("conflict_wb_addr",  128'(wb_addr), 128'h4);
    chk("conflict_wb_data",  wb_data, 128'hDEADBEEF_12340A09_0807AA05_84030201);
    chk("conflict_fetch_addr", 128'(rd_addr), 128'h14);

    // read and write together: no access
    read = 1'b1; write = 1'b1; funct3 = 3'b010; address = 32'h300; writedata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clock);
      chk("both_busywait",  128'(busywait),  128'd0);
      chk("both_mem_read",  128'(mem_read),  128'd0);
      chk("both_mem_write", 128'(mem_write), 128'd0);
    end
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;

    // Reset during a fetch
    mem_lat = 3;
    read = 1'b1; write = 1'b0; funct3 = 3'b010; address = 32'h40;
    n = 0;
    @(negedge clock);
    while (mem_read !== 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("reach_fetch", 128'(mem_read), 128'd1);
    @(posedge clock); #1;
    reset = 1'b1; read = 1'b0;
    #1;
    chk("midreset_mem_read",    128'(mem_read),    128'd0);
    chk("midreset_mem_write",   128'(mem_write),   128'd0);
    chk("midreset_busywait",    128'(busywait),    128'd0);
    chk("midreset_mem_address", 128'(mem_address), 128'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
    end
    mem_lat = 2;
    run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rdata, stall);
    chk("post_reset_readdata", 128'(rdata), 128'h84030201);
    chk("post_reset_missed",   128'(stall != 0), 128'd1);

    // Random traffic
    tags[0] = 25'h0;
    tags[1] = 25'h1;
    tags[2] = 25'h0ABCD;
    tags[3] = 25'h1FFFFFF;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      bit          st;
      int          sel;
      st  = ($urandom_range(0, 2) == 0);
      a   = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      sel = $urandom_range(0, 4);
      if (st) f3 = 3'(sel % 3);
      else    f3 = (sel == 3) ? 3'b100 : (sel == 4) ? 3'b101 : 3'(sel);
      mem_lat = $urandom_range(1, 3);
      run_op(!st, st, f3, a, $urandom, rdata, stall);
    end

    chk("no_read_write_overlap", 128'(overlap), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
